// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: write-back select encodings, the
// default datapath width and the packed EX control bundle.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wbsel_e;

    typedef struct packed {
        logic [4:0] RegDst;
        logic       ASel;
        logic       BSel;
        logic       MemRW;
        logic       RegWEn;
        logic [1:0] WBSel;
        logic [3:0] ALUSel;
    } ctrl_t;

    // How the ID/EX register advances on a given (non-reset) cycle.
    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_BUBBLE
    } upd_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX pipeline bus: decoded ID fields in (_i) and registered EX fields out (_o).
interface id_ex_stage_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
);
    logic [4:0]      RegDst_i;
    logic            ASel_i;
    logic            BSel_i;
    logic            MemRW_i;
    logic            RegWEn_i;
    logic [1:0]      WBSel_i;
    logic [3:0]      ALUSel_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic            rs1_used_i;
    logic            rs2_used_i;

    logic [4:0]      RegDst_o;
    logic            ASel_o;
    logic            BSel_o;
    logic            MemRW_o;
    logic            RegWEn_o;
    logic [1:0]      WBSel_o;
    logic [3:0]      ALUSel_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [XLEN-1:0] imm_o;
    logic [4:0]      rs1_addr_o;
    logic [4:0]      rs2_addr_o;
    logic            valid_o;

    modport master (
        output RegDst_i, ASel_i, BSel_i, MemRW_i, RegWEn_i, WBSel_i, ALUSel_i,
        output pc_i, rs1_data_i, rs2_data_i, imm_i,
        output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  RegDst_o, ASel_o, BSel_o, MemRW_o, RegWEn_o, WBSel_o, ALUSel_o,
        input  pc_o, rs1_data_o, rs2_data_o, imm_o,
        input  rs1_addr_o, rs2_addr_o, valid_o
    );

    modport slave (
        input  RegDst_i, ASel_i, BSel_i, MemRW_i, RegWEn_i, WBSel_i, ALUSel_i,
        input  pc_i, rs1_data_i, rs2_data_i, imm_i,
        input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output RegDst_o, ASel_o, BSel_o, MemRW_o, RegWEn_o, WBSel_o, ALUSel_o,
        output pc_o, rs1_data_o, rs2_data_o, imm_o,
        output rs1_addr_o, rs2_addr_o, valid_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection between the EX-stage load and the ID-stage
// source operands, plus the PC / IF-ID write enables derived from it.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic       rst_i,
    input  logic       stall_i,
    input  logic       ex_valid_i,
    input  ctrl_t      ex_ctrl_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    output logic       hazard_o,
    output logic       pc_write_o,
    output logic       ifid_write_o
);

    logic ex_is_load;
    logic src_match;

    always_comb begin
        ex_is_load = ex_valid_i && ex_ctrl_i.RegWEn
                  && (ex_ctrl_i.WBSel == WB_MEM) && (ex_ctrl_i.RegDst != '0);
        src_match  = (rs1_used_i && (rs1_addr_i == ex_ctrl_i.RegDst))
                  || (rs2_used_i && (rs2_addr_i == ex_ctrl_i.RegDst));
        // Masked during reset: EX may still hold pre-reset contents this cycle.
        hazard_o     = !rst_i && ex_is_load && src_match;
        pc_write_o   = !hazard_o && !stall_i;
        ifid_write_o = !hazard_o && !stall_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// global stall hold and a saturating bubble counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    id_ex_stage_if.slave     bus,
    output logic             Hazard_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [4:0]       rs1_addr_q, rs1_addr_d;
    logic [4:0]       rs2_addr_q, rs2_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    upd_e             upd;

    hazard_unit u_hazard (
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .ex_valid_i   (valid_q),
        .ex_ctrl_i    (ctrl_q),
        .rs1_addr_i   (bus.rs1_addr_i),
        .rs2_addr_i   (bus.rs2_addr_i),
        .rs1_used_i   (bus.rs1_used_i),
        .rs2_used_i   (bus.rs2_used_i),
        .hazard_o     (Hazard_o),
        .pc_write_o   (pc_write_o),
        .ifid_write_o (ifid_write_o)
    );

    // Flush and hazard together collapse into one bubble cycle.
    always_comb begin
        upd = UPD_LOAD;
        if (stall_i) begin
            upd = UPD_HOLD;
        end else if (flush_i || Hazard_o) begin
            upd = UPD_BUBBLE;
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        cnt_d      = cnt_q;
        unique case (upd)
            UPD_LOAD: begin
                ctrl_d     = '{RegDst: bus.RegDst_i, ASel: bus.ASel_i, BSel: bus.BSel_i,
                               MemRW: bus.MemRW_i, RegWEn: bus.RegWEn_i,
                               WBSel: bus.WBSel_i, ALUSel: bus.ALUSel_i};
                valid_d    = 1'b1;
                pc_d       = bus.pc_i;
                rs1_data_d = bus.rs1_data_i;
                rs2_data_d = bus.rs2_data_i;
                imm_d      = bus.imm_i;
                rs1_addr_d = bus.rs1_addr_i;
                rs2_addr_d = bus.rs2_addr_i;
            end
            UPD_BUBBLE: begin
                ctrl_d     = '0;
                valid_d    = 1'b0;
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                rs1_addr_d = '0;
                rs2_addr_d = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.RegDst_o   = ctrl_q.RegDst;
    assign bus.ASel_o     = ctrl_q.ASel;
    assign bus.BSel_o     = ctrl_q.BSel;
    assign bus.MemRW_o    = ctrl_q.MemRW;
    assign bus.RegWEn_o   = ctrl_q.RegWEn;
    assign bus.WBSel_o    = ctrl_q.WBSel;
    assign bus.ALUSel_o   = ctrl_q.ALUSel;
    assign bus.valid_o    = valid_q;
    assign bus.pc_o       = pc_q;
    assign bus.rs1_data_o = rs1_data_q;
    assign bus.rs2_data_o = rs2_data_q;
    assign bus.imm_o      = imm_q;
    assign bus.rs1_addr_o = rs1_addr_q;
    assign bus.rs2_addr_o = rs2_addr_q;
    assign bubble_cnt_o   = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 Parameter CNT_W, default 16, width of bubble counter.
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 stall_i  input  1  global back-pressure; hold all ID/EX contents.
REQ-006 flush_i  input  1  taken branch/jump resolved in EX; squash the ID instruction.
REQ-007 RegDst_i  input 5, ASel_i 1, BSel_i 1, MemRW_i 1, RegWEn_i 1, WBSel_i 2, ALUSel_i 4  inputs  control fields from control_mux.
REQ-008 pc_i, rs1_data_i, rs2_data_i, imm_i  input  XLEN each  ID-stage data.
REQ-009 rs1_addr_i, rs2_addr_i  input  5 each; rs1_used_i, rs2_used_i  input  1 each  ID source operands and whether they are read.
REQ-010 RegDst_o, ASel_o, BSel_o, MemRW_o, RegWEn_o, WBSel_o, ALUSel_o  output  same widths  registered EX control.
REQ-011 pc_o, rs1_data_o, rs2_data_o, imm_o  output XLEN; rs1_addr_o, rs2_addr_o  output 5  registered EX data (addresses feed forwarding).
REQ-012 valid_o  output  1  EX stage holds a real instruction.
REQ-013 Hazard_o  output  1  combinational load-use hazard, drives control_mux Hazard_i.
REQ-014 pc_write_o, ifid_write_o  output  1 each  enable for PC and IF/ID registers.
REQ-015 bubble_cnt_o  output  CNT_W  count of bubbles inserted.

Function
REQ-016 Hazard_o SHALL be 1 iff valid_o & RegWEn_o & (WBSel_o == WB_MEM) & (RegDst_o != 0) & ((rs1_used_i & rs1_addr_i == RegDst_o) | (rs2_used_i & rs2_addr_i == RegDst_o)).
REQ-017 pc_write_o = ifid_write_o = ~Hazard_o & ~stall_i, combinational.
REQ-018 Per-cycle priority SHALL be: rst_i > stall_i (hold) > flush_i (bubble) > Hazard_o (bubble) > load.
REQ-019 Load: all *_o data/control capture *_i next edge; valid_o <= 1; latency exactly one cycle.
REQ-020 Bubble: all control outputs and valid_o <= 0; data fields SHALL also be cleared to 0; inputs ignored.
REQ-021 Hold: every register, including bubble_cnt_o, retains value; Hazard_o remains evaluated from held contents.
REQ-022 flush_i and Hazard_o in same cycle SHALL insert a single bubble, counted once.
REQ-023 After a load-use bubble, Hazard_o SHALL deassert next cycle (EX holds the bubble); hazard stall lasts exactly one cycle absent stall_i.
REQ-024 bubble_cnt_o SHALL increment by 1 on each bubble cycle and saturate at all-ones (no wrap).
REQ-025 rd == x0 loads SHALL never raise Hazard_o.

Reset
REQ-026 On rst_i at a clock edge all outputs registered here SHALL be 0 next cycle, overriding stall_i and flush_i, including mid-hazard.
REQ-027 While rst_i asserted, Hazard_o = 0 (valid_o = 0) and pc_write_o = ~stall_i.

Structure
REQ-028 Shared package riscv_pkg SHALL hold WBSel encodings (WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10), XLEN default and a packed struct of the control bundle.
REQ-029 Sub-module hazard_unit SHALL implement REQ-016/REQ-017 combinationally; id_ex_stage instantiates it plus the register and counter.

Verification
REQ-030 Load-use: EX holds lw x5 (RegWEn=1, WBSel=00, RegDst=5), ID add x6,x5,x7 rs1_used=1 -> Hazard_o=1, pc_write_o=0, next cycle valid_o=0, bubble_cnt_o=1, then Hazard_o=0.
REQ-031 Non-load: EX holds add x5 (WBSel=01), ID reads x5 -> Hazard_o=0, next cycle outputs equal inputs, valid_o=1.
REQ-032 x0 load: lw x0, ID reads x0 -> Hazard_o=0.
REQ-033 flush_i=1 with stall_i=1 -> contents held, bubble_cnt_o unchanged; flush_i=1 alone -> valid_o=0, RegWEn_o=0.
REQ-034 Saturation: CNT_W=4, 20 consecutive flushes -> bubble_cnt_o=15.
REQ-035 rst_i=1 with stall_i=1 during a hazard -> next cycle all outputs 0, Hazard_o=0.
